uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 93 +++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: synchronizes the receiver's data_ready level, turns each
// rising edge into a single write of rhr_data, and offers a show-ahead byte queue with overrun flag.
module uart_rx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rhr_data,
  input  logic              data_ready,
  input  logic              rd_en,
  input  logic              clr_overrun,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun
);

  // The write FSM state doubles as the history flop s3 (StHeld == s3 high).
  typedef enum logic {StIdle = 1'b0, StHeld = 1'b1} wr_state_e;

  wr_state_e         wr_state_q;
  logic              s1_q, s2_q;
  logic              wr, rd_acc, wr_acc, drop;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, full_q, overrun_q;
  logic [7:0]        mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      wr_state_q <= StIdle;
    end else begin
      s1_q <= data_ready;
      s2_q <= s1_q;
      case (wr_state_q)
        StIdle:  if (s2_q)  wr_state_q <= StHeld;
        StHeld:  if (!s2_q) wr_state_q <= StIdle;
        default: wr_state_q <= StIdle;
      endcase
    end
  end

  assign wr     = s2_q && (wr_state_q == StIdle);
  assign rd_acc = rd_en && !empty_q;
  // A full FIFO still takes a byte when the same cycle frees a slot.
  assign wr_acc = wr && (!full_q || rd_acc);
  assign drop   = wr && full_q && !rd_en;

  always_comb begin
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == (ADDR_W+1)'(DEPTH));
      // Set wins over clear.
      if (drop)             overrun_q <= 1'b1;
      else if (clr_overrun) overrun_q <= 1'b0;
    end
  end

  // Storage is not reset; stale bytes are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) mem[wr_ptr_q] <= rhr_data;
  end

  assign rd_data = mem[rd_ptr_q];
  assign empty   = empty_q;
  assign full    = full_q;
  assign count   = count_q;
  assign overrun = overrun_q;

endmodule
